alu_control_seq: RTL and testbench
==================================

# alu_control_seq

Registered, parametrised ALU control unit for the multi-cycle MIPS datapath. It decodes `alu_op_i` and the funct field into a 4-bit ALU operation, and adds the HI/LO multiply/divide instructions. It also sequences the multi-cycle mult/div unit with a busy counter and a stall handshake toward the hazard logic. It sits between the main control unit and the ALU/mult-div datapath.

## Interface
- `ALU_OP_W`, 3: width of `alu_op_i`
- `FUNCT_W`, 6: width of the funct field
- `ALU_SEL_W`, 4: width of `alu_operation_o`
- `MULT_LATENCY`, 4: busy cycles per MULT/MULTU; must be ≥2
- `DIV_LATENCY`, 32: busy cycles per DIV/DIVU; must be ≥2
- `clk`  in  1  the block's only clock
- `reset`  in  1  synchronous, active-high reset
- `valid_i`  in  1  decode request this cycle
- `alu_op_i`  in  ALU_OP_W  class from main control
- `alu_function_i`  in  FUNCT_W  instruction funct field
- `stall_o`  out  1  request not accepted; hold the inputs (combinational)
- `alu_operation_o`  out  ALU_SEL_W  registered ALU operation
- `valid_o`  out  1  `alu_operation_o` is fresh this cycle
- `illegal_o`  out  1  accepted request decoded to ILLEGAL (registered)
- `muldiv_start_o`  out  1  one-cycle start pulse to the mult/div unit
- `busy_o`  out  1  mult/div unit is occupied
- `muldiv_done_o`  out  1  one-cycle pulse in the last busy cycle

## Operation
- `alu_op_i` classes:
  - 111 R-type: decode by funct
  - 000 ADD (lw/sw), 001 SUB (beq), 010 LUI
  - 011 SLT (slti), 100 ADD (addi), 101 OR (ori), 110 AND (andi)
- R-type funct decode:
  - 100000/100001 ADD
  - 100010/100011 SUB
  - 100100 AND, 100101 OR, 100111 NOR
  - 101010 SLT, 000000 SLL, 000010 SRL
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
  - 010000 MFHI, 010010 MFLO
  - anything else ILLEGAL
- Operation codes:
  - AND 0000, NOR 0001, OR 0010, ADD 0011, SUB 0100, SLT 0101
  - SLL 0110, SRL 0111, LUI 1000, ILLEGAL 1001
  - MULT 1010, MULTU 1011, DIV 1100, DIVU 1101, MFHI 1110, MFLO 1111
- "Unit op" means MULT/MULTU/DIV/DIVU/MFHI/MFLO.
- `stall_o` = `valid_i` & unit op & state==BUSY. Non-unit ops are never stalled.
- Accepted request (`valid_i` & !`stall_o`) registers `alu_operation_o`, `valid_o`=1 and `illegal_o`.
- Without an accepted request, `valid_o`=0 and `alu_operation_o`/`illegal_o` hold their values.
- FSM states:
  - IDLE: an accepted MULT* or DIV* pulses `muldiv_start_o`, loads the counter with LATENCY−1 and goes to BUSY.
  - BUSY: counter decrements each cycle. At count 0, `muldiv_done_o`=1 and the next state is IDLE.
- Counter width is `$clog2(max(MULT_LATENCY,DIV_LATENCY))`. It never wraps below 0.

## Timing
- Decode latency is 1 cycle: request accepted at edge N appears on `alu_operation_o`/`valid_o` during cycle N+1.
- `muldiv_start_o` is coincident with `valid_o` of its MULT/DIV.
- `busy_o` is high for exactly LATENCY cycles, N+1 … N+LATENCY. `muldiv_done_o` fires in cycle N+LATENCY.
- Unit op presented in the done cycle is still stalled. It is accepted at the next edge, giving one bubble.
- Back-to-back non-unit ops yield one `valid_o` per cycle, including while BUSY.
- Reset values: `alu_operation_o`=1001, and `valid_o`, `illegal_o`, `muldiv_start_o`, `busy_o`, `muldiv_done_o` are all 0. The FSM returns to IDLE with counter 0.
- Reset during BUSY aborts the operation with no done pulse. `stall_o` drops in the first cycle after the reset edge.

## Configuration
- Macro: `ALU_CTRL_DIV_EN`.
- Defined: DIV/DIVU decode to 1100/1101 and use `DIV_LATENCY`.
- Undefined: funct 011010/011011 decode to ILLEGAL (1001, `illegal_o`=1). They never start the unit and never stall. `DIV_LATENCY` is ignored and the counter is sized from `MULT_LATENCY` alone.

## Structure
- Package `alu_control_pkg` holds:
  - the ALU_SEL operation-code localparams
  - the `alu_op` class codes
  - the funct codes
  - the FSM state enum
- Sub-module `muldiv_sequencer` holds the IDLE/BUSY FSM, counter, start/busy/done outputs and the stall term. The top level keeps decode and the output register.

## Test plan
- Reset, then `alu_op`=111, funct=100000, `valid_i`=1 → next cycle `alu_operation_o`=0011, `valid_o`=1, `illegal_o`=0.
- `alu_op`=101 with any funct → 0010; `alu_op`=111, funct=111111 → 1001 with `illegal_o`=1.
- MULT accepted at edge N, defaults → `muldiv_start_o` in N+1, `busy_o` in N+1..N+4, `muldiv_done_o` in N+4 only.
- MULT, then MFLO held with `valid_i` → `stall_o`=1 through the done cycle; MFLO 1111 emitted one cycle after `busy_o` falls. An ADD issued during BUSY is accepted with no stall.
- DIV running, `reset` asserted at its 10th busy cycle → all outputs at reset values next cycle, no done pulse.
- `ALU_CTRL_DIV_EN` undefined: DIV → 1001, `illegal_o`=1, `busy_o` stays 0.

Source files
------------

// File: rtl/alu_control_pkg.sv
// Shared codes for the ALU control unit: operation selects, main-control
// classes, R-type funct values and the mult/div sequencer state type.
package alu_control_pkg;

    // ALU operation selects driven on alu_operation_o
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_NOR     = 4'b0001;
    localparam logic [3:0] ALU_OR      = 4'b0010;
    localparam logic [3:0] ALU_ADD     = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0100;
    localparam logic [3:0] ALU_SLT     = 4'b0101;
    localparam logic [3:0] ALU_SLL     = 4'b0110;
    localparam logic [3:0] ALU_SRL     = 4'b0111;
    localparam logic [3:0] ALU_LUI     = 4'b1000;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1001;
    localparam logic [3:0] ALU_MULT    = 4'b1010;
    localparam logic [3:0] ALU_MULTU   = 4'b1011;
    localparam logic [3:0] ALU_DIV     = 4'b1100;
    localparam logic [3:0] ALU_DIVU    = 4'b1101;
    localparam logic [3:0] ALU_MFHI    = 4'b1110;
    localparam logic [3:0] ALU_MFLO    = 4'b1111;

    // Operation classes coming from the main control unit
    localparam logic [2:0] OPC_ADD_MEM = 3'b000;
    localparam logic [2:0] OPC_SUB_BR  = 3'b001;
    localparam logic [2:0] OPC_LUI     = 3'b010;
    localparam logic [2:0] OPC_SLTI    = 3'b011;
    localparam logic [2:0] OPC_ADDI    = 3'b100;
    localparam logic [2:0] OPC_ORI     = 3'b101;
    localparam logic [2:0] OPC_ANDI    = 3'b110;
    localparam logic [2:0] OPC_RTYPE   = 3'b111;

    // R-type funct field values
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // Mult/div sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } seq_state_t;

    // Every op that touches the mult/div unit or HI/LO sits in the top six codes
    function automatic logic is_unit_op(input logic [3:0] op);
        return op >= ALU_MULT;
    endfunction

endpackage

// File: rtl/alu_control_seq_muldiv_sequencer.sv
// Mult/div unit sequencer: IDLE/BUSY FSM, busy counter, start/busy/done
// outputs and the stall term for HI/LO and mult/div requests.
// ALU_CTRL_DIV_EN: when defined, DIV/DIVU launch the unit with DIV_LATENCY.
module muldiv_sequencer
    import alu_control_pkg::*;
#(
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    input  logic [3:0] op_i,
    output logic       stall_o,
    output logic       muldiv_start_o,
    output logic       busy_o,
    output logic       muldiv_done_o
);

`ifdef ALU_CTRL_DIV_EN
    localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
`else
    localparam int MAX_LAT = MULT_LATENCY;
`endif
    localparam int CNT_W = $clog2(MAX_LAT);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY - 1);

    // A one-cycle-or-shorter busy window cannot be sequenced
    if (MULT_LATENCY < 2 || DIV_LATENCY < 2) begin : g_bad_latency
        $error("muldiv_sequencer: latencies must be at least 2");
    end

    seq_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic             r_start, w_start_next;
    logic             w_done;
    logic             w_accept;
    logic             w_launch;
    logic             w_is_div;

    // Unit ops wait while the unit is occupied, including its done cycle
    assign stall_o  = valid_i & is_unit_op(op_i) & (r_state == ST_BUSY);
    assign w_accept = valid_i & ~stall_o;
    assign w_launch = (op_i >= ALU_MULT) && (op_i <= ALU_DIVU);

`ifdef ALU_CTRL_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);
    assign w_is_div = (op_i == ALU_DIV) || (op_i == ALU_DIVU);
`else
    assign w_is_div = 1'b0;
`endif

    // Next state, counter load/decrement and the start/done pulses
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_start_next = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_launch) begin
                    w_start_next = 1'b1;
                    w_state_next = ST_BUSY;
`ifdef ALU_CTRL_DIV_EN
                    w_count_next = w_is_div ? DIV_LOAD : MULT_LOAD;
`else
                    w_count_next = MULT_LOAD;
`endif
                end
            end
            ST_BUSY: begin
                if (r_count == '0) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, counter and start-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_start <= w_start_next;
        end
    end

    assign muldiv_start_o = r_start;
    assign busy_o         = (r_state == ST_BUSY);
    assign muldiv_done_o  = w_done;

    // Only meaningful when the DIV path is built in
    logic w_unused;
    assign w_unused = w_is_div;

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control: decodes class + funct into an ALU operation and
// sequences the multi-cycle mult/div unit through muldiv_sequencer.
// ALU_CTRL_DIV_EN: when defined, DIV/DIVU are legal; otherwise they are ILLEGAL.
module alu_control_seq
    import alu_control_pkg::*;
#(
    parameter int ALU_OP_W     = 3,
    parameter int FUNCT_W      = 6,
    parameter int ALU_SEL_W    = 4,
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [ALU_OP_W-1:0]  alu_op_i,
    input  logic [FUNCT_W-1:0]   alu_function_i,
    output logic                 stall_o,
    output logic [ALU_SEL_W-1:0] alu_operation_o,
    output logic                 valid_o,
    output logic                 illegal_o,
    output logic                 muldiv_start_o,
    output logic                 busy_o,
    output logic                 muldiv_done_o
);

    logic [3:0]           w_dec_op;
    logic                 w_accept;
    logic [ALU_SEL_W-1:0] r_alu_op;
    logic                 r_valid;
    logic                 r_illegal;

    // Class decode, with R-type resolved by funct
    always_comb begin
        w_dec_op = ALU_ILLEGAL;
        case (alu_op_i)
            OPC_ADD_MEM, OPC_ADDI: w_dec_op = ALU_ADD;
            OPC_SUB_BR:            w_dec_op = ALU_SUB;
            OPC_LUI:               w_dec_op = ALU_LUI;
            OPC_SLTI:              w_dec_op = ALU_SLT;
            OPC_ORI:               w_dec_op = ALU_OR;
            OPC_ANDI:              w_dec_op = ALU_AND;
            OPC_RTYPE: begin
                case (alu_function_i)
                    F_ADD, F_ADDU: w_dec_op = ALU_ADD;
                    F_SUB, F_SUBU: w_dec_op = ALU_SUB;
                    F_AND:         w_dec_op = ALU_AND;
                    F_OR:          w_dec_op = ALU_OR;
                    F_NOR:         w_dec_op = ALU_NOR;
                    F_SLT:         w_dec_op = ALU_SLT;
                    F_SLL:         w_dec_op = ALU_SLL;
                    F_SRL:         w_dec_op = ALU_SRL;
                    F_MULT:        w_dec_op = ALU_MULT;
                    F_MULTU:       w_dec_op = ALU_MULTU;
`ifdef ALU_CTRL_DIV_EN
                    F_DIV:         w_dec_op = ALU_DIV;
                    F_DIVU:        w_dec_op = ALU_DIVU;
`endif
                    F_MFHI:        w_dec_op = ALU_MFHI;
                    F_MFLO:        w_dec_op = ALU_MFLO;
                    default:       w_dec_op = ALU_ILLEGAL;
                endcase
            end
            default: w_dec_op = ALU_ILLEGAL;
        endcase
    end

    muldiv_sequencer #(
        .MULT_LATENCY (MULT_LATENCY),
        .DIV_LATENCY  (DIV_LATENCY)
    ) u_seq (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .op_i           (w_dec_op),
        .stall_o        (stall_o),
        .muldiv_start_o (muldiv_start_o),
        .busy_o         (busy_o),
        .muldiv_done_o  (muldiv_done_o)
    );

    assign w_accept = valid_i & ~stall_o;

    // Output register: capture on accept, otherwise hold and drop valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_op  <= ALU_SEL_W'(ALU_ILLEGAL);
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_alu_op  <= ALU_SEL_W'(w_dec_op);
                r_illegal <= (w_dec_op == ALU_ILLEGAL);
            end
        end
    end

    assign alu_operation_o = r_alu_op;
    assign valid_o         = r_valid;
    assign illegal_o       = r_illegal;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed cases with literal
// expectations followed by randomized traffic against a behavioural model.
// ALU_CTRL_DIV_EN: selects which DIV behaviour the model and directed cases expect.
module tb_alu_control_seq;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_i = 1'b0;
    logic [2:0] alu_op_i = 3'b000;
    logic [5:0] alu_function_i = 6'b000000;
    logic       stall_o;
    logic [3:0] alu_operation_o;
    logic       valid_o;
    logic       illegal_o;
    logic       muldiv_start_o;
    logic       busy_o;
    logic       muldiv_done_o;

    always #5 clk = ~clk;

    alu_control_seq #(
        .ALU_OP_W     (3),
        .FUNCT_W      (6),
        .ALU_SEL_W    (4),
        .MULT_LATENCY (MULT_LAT),
        .DIV_LATENCY  (DIV_LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .alu_op_i        (alu_op_i),
        .alu_function_i  (alu_function_i),
        .stall_o         (stall_o),
        .alu_operation_o (alu_operation_o),
        .valid_o         (valid_o),
        .illegal_o       (illegal_o),
        .muldiv_start_o  (muldiv_start_o),
        .busy_o          (busy_o),
        .muldiv_done_o   (muldiv_done_o)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Decode tables: funct -> op code and class -> op code
    int fmap[64];
    int cmap[8];
    int legal_f[16] = '{32, 33, 34, 35, 36, 37, 39, 42, 0, 2, 24, 25, 26, 27, 16, 18};

    // Model state: registered outputs and remaining busy cycles
    int   m_busy_left = 0;
    int   m_opreg = 9;
    logic m_valid = 1'b0;
    logic m_ill = 1'b0;
    logic m_start = 1'b0;
    logic last_stall = 1'b0;

    function automatic int model_decode(input logic [2:0] aop, input logic [5:0] fn);
        if (aop == 3'b111) return fmap[fn];
        return cmap[aop];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, check stall, advance model, check outputs
    task automatic step(input logic rst, input logic v, input logic [2:0] aop, input logic [5:0] fn);
        int  op;
        logic unit, stall, accept;
        @(negedge clk);
        reset = rst;
        valid_i = v;
        alu_op_i = aop;
        alu_function_i = fn;
        #1;
        op    = model_decode(aop, fn);
        unit  = (op >= 10);
        stall = v && unit && (m_busy_left > 0);
        last_stall = stall_o;
        chk("stall_o", int'(stall_o), int'(stall));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_opreg = 9; m_ill = 1'b0; m_start = 1'b0; m_busy_left = 0;
        end else begin
            accept  = v && !stall;
            m_valid = accept;
            if (accept) begin
                m_opreg = op;
                m_ill   = (op == 9);
            end
            m_start = accept && (op >= 10) && (op <= 13);
            if (m_start) m_busy_left = (op >= 12) ? DIV_LAT : MULT_LAT;
            else if (m_busy_left > 0) m_busy_left--;
        end
        #1;
        chk("valid_o", int'(valid_o), int'(m_valid));
        chk("alu_operation_o", int'(alu_operation_o), m_opreg);
        chk("illegal_o", int'(illegal_o), int'(m_ill));
        chk("muldiv_start_o", int'(muldiv_start_o), int'(m_start));
        chk("busy_o", int'(busy_o), int'(m_busy_left > 0));
        chk("muldiv_done_o", int'(muldiv_done_o), int'(m_busy_left == 1));
        if (m_valid)
            $display("txn alu_op=%b funct=%b -> op=%b illegal=%b start=%b busy=%b",
                     aop, fn, alu_operation_o, illegal_o, muldiv_start_o, busy_o);
    endtask

    initial begin
        logic [2:0] r_aop;
        logic [5:0] r_fn;
        logic       r_v, r_rst;

        for (int i = 0; i < 64; i++) fmap[i] = 9;
        fmap[32] = 3; fmap[33] = 3; fmap[34] = 4; fmap[35] = 4;
        fmap[36] = 0; fmap[37] = 2; fmap[39] = 1; fmap[42] = 5;
        fmap[0]  = 6; fmap[2]  = 7; fmap[24] = 10; fmap[25] = 11;
        fmap[16] = 14; fmap[18] = 15;
`ifdef ALU_CTRL_DIV_EN
        fmap[26] = 12; fmap[27] = 13;
`endif
        cmap = '{3, 4, 8, 5, 3, 2, 0, 9};

        // Reset values
        step(1'b1, 1'b0, 3'b000, 6'b000000);
        step(1'b1, 1'b0, 3'b000, 6'b000000);
        chk("lit_reset_op", int'(alu_operation_o), 9);
        chk("lit_reset_valid", int'(valid_o), 0);
        chk("lit_reset_busy", int'(busy_o), 0);

        // Plain decodes
        step(1'b0, 1'b1, 3'b111, 6'b100000);
        chk("lit_add_op", int'(alu_operation_o), 3);
        chk("lit_add_valid", int'(valid_o), 1);
        chk("lit_add_ill", int'(illegal_o), 0);
        step(1'b0, 1'b1, 3'b101, 6'($urandom_range(0, 63)));
        chk("lit_ori_op", int'(alu_operation_o), 2);
        step(1'b0, 1'b1, 3'b111, 6'b111111);
        chk("lit_illegal_op", int'(alu_operation_o), 9);
        chk("lit_illegal_flag", int'(illegal_o), 1);
        step(1'b0, 1'b0, 3'b000, 6'b000000);
        chk("lit_idle_valid", int'(valid_o), 0);
        chk("lit_idle_hold", int'(alu_operation_o), 9);

        // MULT, MFLO stalled, ADD through busy, MFLO after busy falls
        step(1'b0, 1'b1, 3'b111, 6'b011000);
        chk("lit_mult_start", int'(muldiv_start_o), 1);
        chk("lit_mult_busy1", int'(busy_o), 1);
        chk("lit_mult_op", int'(alu_operation_o), 10);
        step(1'b0, 1'b1, 3'b111, 6'b010010);
        chk("lit_mflo_stall1", int'(last_stall), 1);
        chk("lit_mult_start_gone", int'(muldiv_start_o), 0);
        step(1'b0, 1'b1, 3'b111, 6'b100000);
        chk("lit_add_busy_nostall", int'(last_stall), 0);
        chk("lit_add_busy_valid", int'(valid_o), 1);
        step(1'b0, 1'b1, 3'b111, 6'b010010);
        chk("lit_mult_done", int'(muldiv_done_o), 1);
        chk("lit_mult_busy4", int'(busy_o), 1);
        step(1'b0, 1'b1, 3'b111, 6'b010010);
        chk("lit_mflo_stall_done", int'(last_stall), 1);
        chk("lit_busy_fell", int'(busy_o), 0);
        chk("lit_no_done_after", int'(muldiv_done_o), 0);
        step(1'b0, 1'b1, 3'b111, 6'b010010);
        chk("lit_mflo_op", int'(alu_operation_o), 15);
        chk("lit_mflo_valid", int'(valid_o), 1);

`ifdef ALU_CTRL_DIV_EN
        // DIV aborted by reset in its 10th busy cycle
        step(1'b0, 1'b1, 3'b111, 6'b011010);
        chk("lit_div_op", int'(alu_operation_o), 12);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'b000, 6'b000000);
        chk("lit_div_busy9", int'(busy_o), 1);
        step(1'b1, 1'b1, 3'b111, 6'b010010);
        chk("lit_abort_busy", int'(busy_o), 0);
        chk("lit_abort_done", int'(muldiv_done_o), 0);
        chk("lit_abort_op", int'(alu_operation_o), 9);
        chk("lit_abort_valid", int'(valid_o), 0);
        step(1'b0, 1'b1, 3'b111, 6'b010010);
        chk("lit_abort_nostall", int'(last_stall), 0);
`else
        // DIV is illegal and never occupies the unit
        step(1'b0, 1'b1, 3'b111, 6'b011010);
        chk("lit_div_illegal_op", int'(alu_operation_o), 9);
        chk("lit_div_illegal_flag", int'(illegal_o), 1);
        chk("lit_div_no_busy", int'(busy_o), 0);
        chk("lit_div_no_start", int'(muldiv_start_o), 0);
        // MULT aborted by reset in its 3rd busy cycle
        step(1'b0, 1'b1, 3'b111, 6'b011001);
        step(1'b0, 1'b0, 3'b000, 6'b000000);
        step(1'b1, 1'b1, 3'b111, 6'b010010);
        chk("lit_abort_busy", int'(busy_o), 0);
        chk("lit_abort_done", int'(muldiv_done_o), 0);
        chk("lit_abort_op", int'(alu_operation_o), 9);
        step(1'b0, 1'b1, 3'b111, 6'b010010);
        chk("lit_abort_nostall", int'(last_stall), 0);
`endif

        // Randomized traffic; stalled requests are usually held
        r_aop = 3'b000; r_fn = 6'b000000; r_v = 1'b0;
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 149) == 0);
            if (!(last_stall && $urandom_range(0, 4) != 0)) begin
                r_v   = ($urandom_range(0, 9) < 7);
                r_aop = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
                r_fn  = ($urandom_range(0, 3) != 0) ? 6'(legal_f[$urandom_range(0, 15)])
                                                    : 6'($urandom_range(0, 63));
            end
            step(r_rst, r_v, r_aop, r_fn);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
